div_inverse_checker: RTL and testbench
======================================

// Module: div_inverse_checker
// PURPOSE
//  Inverse of the array divider: consumes one divider result (q, r) with its
//  operands (n, d) and rebuilds n' = q*d + r using a sequential shift-add multiplier.
//  Reports |n - n'| per sample and keeps running error statistics (sum, max, count)
//  for exact-vs-approximate divider characterisation (MAE = err_sum / sample_cnt).
//  Sits beside the divider in the evaluation harness; one sample in flight at a time.
// PARAMETERS
//  N_W    16  dividend / reconstruction width
//  D_W     8  divisor, quotient and remainder width
//  ACC_W  32  err_sum width (saturating)
//  CNT_W  16  sample_cnt width (saturating)
// PORTS
//  clk         in   1      clock, all flops on rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      sample present on n/d/q/r
//  in_ready    out  1      block can accept a sample (IDLE only)
//  n           in   N_W    original dividend
//  d           in   D_W    divisor
//  q           in   D_W    divider quotient
//  r           in   D_W    divider remainder
//  clear       in   1      synchronous clear of err_sum/err_max/sample_cnt
//  out_valid   out  1      result registers valid
//  out_ready   in   1      consumer accepts result
//  recon       out  N_W    q*d + r
//  abs_err     out  N_W    |n - recon|
//  mismatch    out  1      abs_err != 0
//  div_by_zero out  1      captured d == 0
//  err_sum     out  ACC_W  sum of abs_err over counted samples
//  err_max     out  N_W    max abs_err over counted samples
//  sample_cnt  out  CNT_W  number of counted samples
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1 once rst drops; every other output 0.
//  FSM: IDLE -(in_valid&&in_ready)-> MUL -(8th step)-> CMP -> DONE -(out_ready)-> IDLE.
//  Accept edge E0 latches n,d,q,r; acc := {0,r}; step idx := 0.
//  MUL, edges E1..E8: if q[idx] then acc += d << idx; idx++. Exactly 8 cycles.
//  CMP, edge E9: recon := acc; abs_err := (n>=acc) ? n-acc : acc-n.
//   Also sets mismatch and div_by_zero; out_valid rises, so latency = 9 cycles after accept.
//  Width: max q*d+r = 255*255+255 = 65280 < 2^16, so no overflow in acc.
//  Stats update at E9 only when d != 0: err_sum += abs_err (saturate at all-ones).
//   err_max := max(err_max, abs_err); sample_cnt += 1 (saturate at all-ones).
//  d == 0: recon = r, abs_err computed as usual, div_by_zero=1, stats untouched.
//  DONE: recon/abs_err/flags held stable while out_valid && !out_ready.
//   Handshake edge: out_valid falls, state IDLE, in_ready rises the next cycle.
//   No overlap of input and output transfers.
//  in_ready = (state==IDLE); in_valid ignored in every other state.
//  clear: zeroes stats at the edge it is sampled. If coincident with E9, clear wins:
//   the current sample is excluded from stats but its per-sample outputs still appear.
//  clear does not disturb the FSM or the per-sample outputs.
//  rst asserted mid-operation: immediate return to reset values, sample discarded.
// STRUCTURE
//  Package div_check_pkg: N_W/D_W defaults, state enum {IDLE,MUL,CMP,DONE}, MUL_STEPS=8.
//  Sub-module recon_shift_add: registered acc + 3-bit idx.
//   Ports: load, step, q/d/r in; acc out and last_step out.
//  Top module holds FSM, compare/abs-diff, stats and handshake.
// TESTING
//  1 n=1000,d=7,q=142,r=6 -> recon=1000, abs_err=0, mismatch=0.
//    out_valid exactly 9 cycles after accept; sample_cnt=1.
//  2 n=1000,d=7,q=143,r=0 -> recon=1001, abs_err=1, mismatch=1.
//    err_sum=1, err_max=1; a follow-up sample with abs_err=5 gives err_sum=6, err_max=5.
//  3 n=65280,d=255,q=255,r=255 -> recon=65280, abs_err=0 (no wrap).
//    Also n=0 with the same q/d/r -> abs_err=65280.
//  4 d=0,q=3,r=9,n=50 -> recon=9, abs_err=41, div_by_zero=1; stats unchanged.
//  5 Backpressure: out_ready low 5 cycles -> outputs stable and in_ready=0 throughout.
//    in_valid pulses in that window are ignored; in_ready=1 the cycle after the handshake.
//  6 rst at 4th MUL cycle -> all outputs 0, IDLE. Next, clear coincident with E9
//    -> stats 0 and sample_cnt 0, while recon/abs_err still valid.

Source files
------------

// File: rtl/div_check_pkg.sv
// Shared definitions for the divider inverse checker.
// Contents: default operand widths, the checker FSM state type and the
// number of shift-add steps needed to multiply by an 8-bit quotient.
package div_check_pkg;

    localparam int N_W_DEF   = 16;
    localparam int D_W_DEF   = 8;
    localparam int MUL_STEPS = 8;
    localparam int IDX_W     = $clog2(MUL_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/recon_shift_add.sv
// Sequential shift-add multiplier that rebuilds q*d + r.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   load_i        capture q/d, seed the accumulator with r, restart the step index
//   step_i        perform one partial-product step (bit idx of q)
//   q_i, d_i, r_i quotient, divisor and remainder operands
//   acc_o         running accumulator (final value after MUL_STEPS steps)
//   last_step_o   high while the step index points at the final quotient bit
module recon_shift_add
    import div_check_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [D_W-1:0] q_i,
    input  logic [D_W-1:0] d_i,
    input  logic [D_W-1:0] r_i,
    output logic [N_W-1:0] acc_o,
    output logic           last_step_o
);

    logic [IDX_W-1:0] idx_q;
    logic [D_W-1:0]   q_q;
    logic [D_W-1:0]   d_q;
    logic [N_W-1:0]   acc_q;

    // Step index is control: it decides when the multiply is finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (load_i) begin
            idx_q <= '0;
        end else if (step_i) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    // Operand and accumulator datapath; a discarded sample is simply reloaded.
    always_ff @(posedge clk) begin
        if (load_i) begin
            q_q   <= q_i;
            d_q   <= d_i;
            acc_q <= N_W'(r_i);
        end else if (step_i && q_q[idx_q]) begin
            acc_q <= acc_q + (N_W'(d_q) << idx_q);
        end
    end

    assign acc_o       = acc_q;
    assign last_step_o = (idx_q == IDX_W'(MUL_STEPS - 1));

endmodule

// File: rtl/div_inverse_checker.sv
// Divider inverse checker: rebuilds n' = q*d + r for one divider result at a
// time and reports |n - n'| plus running error statistics (sum, max, count).
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   sample handshake (accepted only in IDLE)
//   n, d, q, r          dividend, divisor, quotient, remainder
//   clear               synchronous clear of err_sum/err_max/sample_cnt
//   out_valid/out_ready result handshake
//   recon, abs_err      reconstruction and absolute error of the last sample
//   mismatch            abs_err != 0
//   div_by_zero         the sample had d == 0 (excluded from statistics)
//   err_sum, err_max    saturating error sum and maximum over counted samples
//   sample_cnt          saturating number of counted samples
module div_inverse_checker
    import div_check_pkg::*;
#(
    parameter int N_W   = N_W_DEF,
    parameter int D_W   = D_W_DEF,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_W-1:0]   n,
    input  logic [D_W-1:0]   d,
    input  logic [D_W-1:0]   q,
    input  logic [D_W-1:0]   r,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_W-1:0]   recon,
    output logic [N_W-1:0]   abs_err,
    output logic             mismatch,
    output logic             div_by_zero,
    output logic [ACC_W-1:0] err_sum,
    output logic [N_W-1:0]   err_max,
    output logic [CNT_W-1:0] sample_cnt
);

    function automatic logic [ACC_W-1:0] sat_add_sum(input logic [ACC_W-1:0] a,
                                                    input logic [N_W-1:0]   b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(b);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] a);
        return (a == {CNT_W{1'b1}}) ? a : a + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic             accept, load, step;
    logic             last_step;
    logic [N_W-1:0]   acc;
    logic [N_W-1:0]   n_q;
    logic             dz_q;
    logic [N_W-1:0]   abs_err_d;

    logic [N_W-1:0]   recon_q, abs_err_q;
    logic             mismatch_q, dz_out_q;
    logic [ACC_W-1:0] err_sum_q;
    logic [N_W-1:0]   err_max_q;
    logic [CNT_W-1:0] cnt_q;

    recon_shift_add #(
        .N_W (N_W),
        .D_W (D_W)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .step_i      (step),
        .q_i         (q),
        .d_i         (d),
        .r_i         (r),
        .acc_o       (acc),
        .last_step_o (last_step)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = MUL;
            MUL:     if (last_step) state_d = CMP;
            CMP:                    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM outputs; in_ready is held low while reset is asserted
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready;
        load      = accept;
        step      = (state_q == MUL);
    end

    // Sample capture at accept
    always_ff @(posedge clk) begin
        if (load) begin
            n_q  <= n;
            dz_q <= (d == '0);
        end
    end

    assign abs_err_d = (n_q >= acc) ? (n_q - acc) : (acc - n_q);

    // Per-sample result registers, written once at the compare edge and held
    // through DONE and IDLE until the next compare or a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recon_q    <= '0;
            abs_err_q  <= '0;
            mismatch_q <= 1'b0;
            dz_out_q   <= 1'b0;
        end else if (state_q == CMP) begin
            recon_q    <= acc;
            abs_err_q  <= abs_err_d;
            mismatch_q <= (abs_err_d != '0);
            dz_out_q   <= dz_q;
        end
    end

    // Statistics: clear has priority over a coincident compare-edge update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sum_q <= '0;
            err_max_q <= '0;
            cnt_q     <= '0;
        end else if (clear) begin
            err_sum_q <= '0;
            err_max_q <= '0;
            cnt_q     <= '0;
        end else if (state_q == CMP && !dz_q) begin
            err_sum_q <= sat_add_sum(err_sum_q, abs_err_d);
            if (abs_err_d > err_max_q) begin
                err_max_q <= abs_err_d;
            end
            cnt_q     <= sat_inc_cnt(cnt_q);
        end
    end

    assign recon       = recon_q;
    assign abs_err     = abs_err_q;
    assign mismatch    = mismatch_q;
    assign div_by_zero = dz_out_q;
    assign err_sum     = err_sum_q;
    assign err_max     = err_max_q;
    assign sample_cnt  = cnt_q;

endmodule

// File: tb/tb_div_inverse_checker.sv
// Directed bench for div_inverse_checker with an arithmetic reference model.
module tb_div_inverse_checker;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [15:0] n;
    logic [7:0]  d, q, r;
    logic        clear;
    logic        out_valid, out_ready;
    logic [15:0] recon, abs_err;
    logic        mismatch, div_by_zero;
    logic [31:0] err_sum;
    logic [15:0] err_max;
    logic [15:0] sample_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    int      exp_recon, exp_abs;
    bit      exp_dz;
    longint  m_sum;
    int      m_max, m_cnt;

    div_inverse_checker dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .n           (n),
        .d           (d),
        .q           (q),
        .r           (r),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .recon       (recon),
        .abs_err     (abs_err),
        .mismatch    (mismatch),
        .div_by_zero (div_by_zero),
        .err_sum     (err_sum),
        .err_max     (err_max),
        .sample_cnt  (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Predict per-sample outputs and statistics for one sample.
    task automatic model_sample(input int tn, input int td, input int tq, input int tr,
                                input bit clr9);
        exp_recon = tq * td + tr;
        exp_abs   = (tn >= exp_recon) ? tn - exp_recon : exp_recon - tn;
        exp_dz    = (td == 0);
        if (clr9) begin
            m_sum = 0; m_max = 0; m_cnt = 0;
        end else if (td != 0) begin
            m_sum = m_sum + exp_abs;
            if (m_sum > 64'h0000_0000_FFFF_FFFF) m_sum = 64'h0000_0000_FFFF_FFFF;
            if (exp_abs > m_max) m_max = exp_abs;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    endtask

    // Compare process: whenever a result is presented, it must match the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                chk("recon",       32'(recon),       32'(exp_recon));
                chk("abs_err",     32'(abs_err),     32'(exp_abs));
                chk("mismatch",    32'(mismatch),    32'(exp_abs != 0));
                chk("div_by_zero", 32'(div_by_zero), 32'(exp_dz));
                chk("err_sum",     err_sum,          32'(m_sum));
                chk("err_max",     32'(err_max),     32'(m_max));
                chk("sample_cnt",  32'(sample_cnt),  32'(m_cnt));
            end
        end
    end

    task automatic send(input int tn, input int td, input int tq, input int tr,
                        input bit clr9, input int hold);
        int  w;
        bit  early;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        model_sample(tn, td, tq, tr, clr9);
        n = 16'(tn); d = 8'(td); q = 8'(tq); r = 8'(tr);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);               // E0
        #1 in_valid = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 9 && clr9) clear = 1'b1;
            @(posedge clk);
            #1;
            if (k < 9 && out_valid) early = 1'b1;
        end
        clear = 1'b0;
        chk("valid_early", 32'(early), 32'd0);
        chk("latency9", 32'(out_valid), 32'd1);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                in_valid = h[0];
                n = 16'h1234; d = 8'd3; q = 8'd1; r = 8'd0;
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);               // handshake edge
        #1;
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        n = '0; d = '0; q = '0; r = '0;
        m_sum = 0; m_max = 0; m_cnt = 0;
        exp_recon = 0; exp_abs = 0; exp_dz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid",  32'(out_valid),  0);
        chk("rst_recon",      32'(recon),      0);
        chk("rst_err_sum",    err_sum,         0);
        chk("rst_sample_cnt", 32'(sample_cnt), 0);
        @(negedge clk) rst = 1'b0;
        #1 chk("rst_in_ready", 32'(in_ready), 1);

        // 1: exact result
        send(1000, 7, 142, 6, 1'b0, 0);
        chk("t1_recon",    32'(recon),      1000);
        chk("t1_abs_err",  32'(abs_err),    0);
        chk("t1_mismatch", 32'(mismatch),   0);
        chk("t1_cnt",      32'(sample_cnt), 1);

        // 2: off-by-one quotient, then an error of 5
        send(1000, 7, 143, 0, 1'b0, 0);
        chk("t2_recon",    32'(recon),    1001);
        chk("t2_abs_err",  32'(abs_err),  1);
        chk("t2_mismatch", 32'(mismatch), 1);
        chk("t2_sum",      err_sum,       1);
        chk("t2_max",      32'(err_max),  1);
        send(100, 10, 9, 5, 1'b0, 0);
        chk("t2b_sum", err_sum,      6);
        chk("t2b_max", 32'(err_max), 5);

        // 3: largest reconstruction, no wrap
        send(65280, 255, 255, 255, 1'b0, 0);
        chk("t3_recon",   32'(recon),   65280);
        chk("t3_abs_err", 32'(abs_err), 0);
        send(0, 255, 255, 255, 1'b0, 0);
        chk("t3b_abs_err", 32'(abs_err), 65280);
        chk("t3b_sum",     err_sum,      65286);

        // 4: divide by zero leaves statistics alone
        send(50, 0, 3, 9, 1'b0, 0);
        chk("t4_recon",   32'(recon),       9);
        chk("t4_abs_err", 32'(abs_err),     41);
        chk("t4_dz",      32'(div_by_zero), 1);
        chk("t4_cnt",     32'(sample_cnt),  5);
        chk("t4_sum",     err_sum,          65286);

        // 5: backpressure with ignored in_valid pulses
        send(200, 20, 10, 0, 1'b0, 5);
        chk("t5_cnt", 32'(sample_cnt), 6);

        // 6: reset during the 4th multiply cycle
        @(negedge clk);
        n = 16'd500; d = 8'd9; q = 8'd55; r = 8'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        m_sum = 0; m_max = 0; m_cnt = 0;
        chk("mr_out_valid", 32'(out_valid),   0);
        chk("mr_recon",     32'(recon),       0);
        chk("mr_abs_err",   32'(abs_err),     0);
        chk("mr_mismatch",  32'(mismatch),    0);
        chk("mr_dz",        32'(div_by_zero), 0);
        chk("mr_sum",       err_sum,          0);
        chk("mr_max",       32'(err_max),     0);
        chk("mr_cnt",       32'(sample_cnt),  0);
        @(negedge clk) rst = 1'b0;
        #1 chk("mr_in_ready", 32'(in_ready), 1);

        // clear coincident with the compare edge
        send(300, 10, 29, 0, 1'b0, 0);
        chk("t6_pre_cnt", 32'(sample_cnt), 1);
        send(1000, 7, 143, 0, 1'b1, 0);
        chk("t6_recon",   32'(recon),      1001);
        chk("t6_abs_err", 32'(abs_err),    1);
        chk("t6_sum",     err_sum,         0);
        chk("t6_max",     32'(err_max),    0);
        chk("t6_cnt",     32'(sample_cnt), 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
